ui_debounce: RTL and testbench
==============================

# ui_debounce

Input conditioning stage in front of the design's registered input byte. Synchronises each asynchronous `ui_in` pin into the `clk` domain and rejects glitches with a per-bit stability counter. Presents a clean byte plus per-bit rise/fall strobes and a byte-level change strobe to the downstream capture register.

## Interface

**Parameters**
- `WIDTH`, 8: number of input bits conditioned.
- `SYNC_STAGES`, 2: flops in each bit's synchroniser chain; legal range ≥2.
- `STABLE_CYCLES`, 8: consecutive post-sync cycles a new level must hold before it is accepted; legal range ≥1.

**Ports**
- `clk`, input, 1: single clock for the whole block.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `ena`, input, 1: advance enable. When 0, debounce state freezes.
- `din`, input, WIDTH: raw asynchronous pins (`ui_in`).
- `dout`, output, WIDTH: debounced, registered byte.
- `rise`, output, WIDTH: one-cycle pulse per bit when `dout[i]` goes 0→1.
- `fall`, output, WIDTH: one-cycle pulse per bit when `dout[i]` goes 1→0.
- `changed`, output, 1: one-cycle pulse when any `dout` bit changed on this edge.

## Operation

- Bits are fully independent. Per bit, the state is:
  - synchroniser chain `sync[SYNC_STAGES-1:0]`;
  - counter `cnt` of width `$clog2(STABLE_CYCLES+1)`;
  - accepted level `dout[i]`.
- The synchroniser shifts every clock regardless of `ena`.
- Define `s` as the last stage of the synchroniser.
- With `ena=1`, each edge:
  - If `s == dout[i]`: `cnt <= 0`.
  - If `s != dout[i]` and `cnt < STABLE_CYCLES-1`: `cnt <= cnt+1`.
  - If `s != dout[i]` and `cnt == STABLE_CYCLES-1`:
    - `dout[i] <= s` and `cnt <= 0`.
    - `rise[i] <= s` and `fall[i] <= ~s` on this same edge.
- `rise`/`fall` bits not updating on an edge are driven 0 (pulses, never held).
- `changed <= |(rise_next | fall_next)` is registered on the same edge as `dout`.
- With `ena=0`:
  - `cnt` and `dout` hold.
  - `rise`, `fall` and `changed` are 0 from the next edge.
- Glitch rule: any return of `s` to `dout[i]` before acceptance zeroes `cnt`. A pulse shorter than `STABLE_CYCLES` post-sync cycles never reaches `dout`.
- Simultaneous changes on several bits:
  - Each bit accepts independently.
  - `changed` is a single pulse when they accept on the same edge.
  - `changed` pulses separately when they accept on different edges.
- `STABLE_CYCLES == 1`: a level is accepted on the first edge it is seen at `s`.
- Reset (asserting `rst_n` low, at any time including mid-count):
  - Immediately clears all sync flops, `cnt`, `dout`, `rise`, `fall` and `changed` to 0.
  - No pulse is generated by reset or by its release.

## Timing

- Clean step on `din[i]` with `ena=1` throughout:
  - `dout[i]` updates on the `SYNC_STAGES + STABLE_CYCLES`-th rising edge after the step; 10 edges with defaults.
  - `rise`/`fall`/`changed` are high for exactly the cycle following that edge.
- All outputs are registered; there are no combinational paths from `din` or `ena` to outputs.
- `ena` low for N cycles during a count delays acceptance by exactly N cycles, provided `s` stays constant.
- After reset release with `din` all 1: first `rise` pulse on edge `SYNC_STAGES + STABLE_CYCLES`.

## Structure

- Shared package `ui_debounce_pkg` holds:
  - default constants `UI_WIDTH=8`, `UI_SYNC_STAGES=2`, `UI_STABLE_CYCLES=8`;
  - the counter-width function `cnt_w(stable)`.
- Sub-module `debounce_bit` contains one bit's synchroniser, counter, level register and `rise`/`fall` logic.
- `ui_debounce` generates `WIDTH` instances of `debounce_bit` and registers `changed` from the OR of their next-state pulses.

## Test plan

- **Reset**: hold `rst_n=0` with `din=8'hFF`, release → `dout=8'h00` until edge 10 after release, then `dout=8'hFF`, `rise=8'hFF`, `changed=1` for one cycle, `fall=0`.
- **Glitch rejection**: from settled `dout=8'h00`, drive `din[3]=1` for 7 post-sync cycles then 0 → `dout` stays `8'h00`, no pulses. Repeat with 8 cycles → `dout=8'h08`, `rise=8'h08`.
- **Falling edge and latency**: settled `dout=8'h5A`, step `din` to `8'h50` → exactly 10 edges later `dout=8'h50`, `fall=8'h0A`, `rise=0`, one `changed` pulse.
- **Staggered bits**: step `din[0]` at cycle 0 and `din[7]` at cycle 3 → `rise=8'h01` at edge 10 and `rise=8'h80` at edge 13, two separate `changed` pulses.
- **Enable freeze**: step `din[1]`, drop `ena` for 5 cycles after 4 counted cycles → `dout[1]` updates at edge 15 instead of 10, no pulses while `ena=0`.
- **Mid-count reset**: step `din=8'hFF`, assert `rst_n` low at edge 6 for 2 cycles → outputs 0 immediately on assertion. After release, acceptance takes the full 10 edges again.

Source files
------------

// File: rtl/ui_debounce_pkg.sv
// Shared constants and helpers for the input debounce stage.
package ui_debounce_pkg;

  localparam int UI_WIDTH         = 8;
  localparam int UI_SYNC_STAGES   = 2;
  localparam int UI_STABLE_CYCLES = 8;

  // Counter must be able to hold values up to STABLE_CYCLES.
  function automatic int cnt_w(input int stable);
    return $clog2(stable + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: synchroniser chain, stability counter, accepted level and edge pulses.
module debounce_bit
  import ui_debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = UI_SYNC_STAGES,
  parameter int STABLE_CYCLES = UI_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic pulse_next
);

  localparam int            CW     = cnt_w(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_TC = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   lvl_q, lvl_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // The synchroniser keeps shifting while ena is low so it never holds stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    lvl_d  = lvl_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (ena) begin
      if (s == lvl_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_TC) begin
        cnt_d  = '0;
        lvl_d  = s;
        rise_d = s;
        fall_d = ~s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign dout       = lvl_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign pulse_next = rise_d | fall_d;

endmodule

// File: rtl/ui_debounce.sv
// Debounced input byte: WIDTH independent bit conditioners plus a shared change strobe.
module ui_debounce
  import ui_debounce_pkg::*;
#(
  parameter int WIDTH         = UI_WIDTH,
  parameter int SYNC_STAGES   = UI_SYNC_STAGES,
  parameter int STABLE_CYCLES = UI_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  logic [WIDTH-1:0] pulse_next;
  logic             changed_q, changed_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .din       (din[i]),
      .dout      (dout[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .pulse_next(pulse_next[i])
    );
  end

  // Registered from the bits' next-state pulses so it lines up with rise/fall.
  assign changed_d = |pulse_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) changed_q <= 1'b0;
    else        changed_q <= changed_d;
  end

  assign changed = changed_q;

endmodule

// File: tb/tb_ui_debounce.sv
// Directed plus randomized checks of ui_debounce against a streak-counting reference model.
module tb_ui_debounce;

  localparam int W  = 8;
  localparam int SS = 2;
  localparam int SC = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic [W-1:0] din;
  logic [W-1:0] dout, rise, fall;
  logic         changed;

  int vectors    = 0;
  int miscompares = 0;

  ui_debounce #(.WIDTH(W), .SYNC_STAGES(SS), .STABLE_CYCLES(SC)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .din    (din),
    .dout   (dout),
    .rise   (rise),
    .fall   (fall),
    .changed(changed)
  );

  always #5 clk = ~clk;

  // Reference model: a delay line of raw samples feeds a per-bit run length of disagreement.
  logic [W-1:0] dly[$];
  int           streak[W];
  logic [W-1:0] m_dout, m_rise, m_fall;
  logic         m_changed;

  function automatic void model_reset();
    dly.delete();
    repeat (SS) dly.push_back('0);
    foreach (streak[i]) streak[i] = 0;
    m_dout    = '0;
    m_rise    = '0;
    m_fall    = '0;
    m_changed = 1'b0;
  endfunction

  function automatic void model_edge(input logic [W-1:0] d, input logic e);
    logic [W-1:0] seen;
    seen = dly.pop_front();
    dly.push_back(d);
    m_rise = '0;
    m_fall = '0;
    if (e) begin
      for (int i = 0; i < W; i++) begin
        if (seen[i] == m_dout[i]) begin
          streak[i] = 0;
        end else begin
          streak[i]++;
          if (streak[i] == SC) begin
            streak[i] = 0;
            m_dout[i] = seen[i];
            if (seen[i]) m_rise[i] = 1'b1;
            else         m_fall[i] = 1'b1;
          end
        end
      end
    end
    m_changed = |(m_rise | m_fall);
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle(input logic [W-1:0] d, input logic e);
    din = d;
    ena = e;
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge(d, e);
    #1;
    check("dout", dout, m_dout);
    check("rise", rise, m_rise);
    check("fall", fall, m_fall);
    check("changed", {7'b0, changed}, {7'b0, m_changed});
  endtask

  // Asynchronous assertion between edges; outputs must clear without a clock.
  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_dout", dout, 8'h00);
    check("rst_rise", rise, 8'h00);
    check("rst_fall", fall, 8'h00);
    check("rst_changed", {7'b0, changed}, 8'h00);
  endtask

  initial begin
    int pulses;
    logic [W-1:0] d;
    int hold;

    rst_n = 1'b0;
    din   = 8'hFF;
    ena   = 1'b1;
    model_reset();
    #1;
    repeat (3) cycle(8'hFF, 1'b1);
    rst_n = 1'b1;

    // Reset release with all inputs high
    for (int i = 1; i <= 11; i++) begin
      cycle(8'hFF, 1'b1);
      if (i == 9) check("rel_dout_e9", dout, 8'h00);
      if (i == 10) begin
        check("rel_dout_e10", dout, 8'hFF);
        check("rel_rise_e10", rise, 8'hFF);
        check("rel_fall_e10", fall, 8'h00);
        check("rel_changed_e10", {7'b0, changed}, 8'h01);
      end
      if (i == 11) check("rel_changed_e11", {7'b0, changed}, 8'h00);
    end

    repeat (12) cycle(8'h00, 1'b1);

    // Glitch of 7 post-sync cycles is rejected
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle((i <= 7) ? 8'h08 : 8'h00, 1'b1);
      pulses += int'(changed);
    end
    check("glitch7_pulses", 8'(pulses), 8'h00);
    check("glitch7_dout", dout, 8'h00);

    // 8 cycles is accepted on edge 10
    for (int i = 1; i <= 20; i++) begin
      cycle((i <= 8) ? 8'h08 : 8'h00, 1'b1);
      if (i == 10) begin
        check("glitch8_dout", dout, 8'h08);
        check("glitch8_rise", rise, 8'h08);
      end
    end

    // Falling edge latency
    repeat (12) cycle(8'h5A, 1'b1);
    check("settle_5a", dout, 8'h5A);
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle(8'h50, 1'b1);
      pulses += int'(changed);
      if (i == 9) check("fall_dout_e9", dout, 8'h5A);
      if (i == 10) begin
        check("fall_dout_e10", dout, 8'h50);
        check("fall_fall_e10", fall, 8'h0A);
        check("fall_rise_e10", rise, 8'h00);
      end
    end
    check("fall_changed_count", 8'(pulses), 8'h01);

    // Async reset while the output is non-zero
    async_reset();
    cycle(8'h00, 1'b1);
    rst_n = 1'b1;

    // Staggered bits
    pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      cycle((i >= 4) ? 8'h81 : 8'h01, 1'b1);
      pulses += int'(changed);
      if (i == 10) check("stag_rise_e10", rise, 8'h01);
      if (i == 13) check("stag_rise_e13", rise, 8'h80);
    end
    check("stag_changed_count", 8'(pulses), 8'h02);

    repeat (12) cycle(8'h00, 1'b1);

    // Enable freeze delays acceptance by the frozen cycles
    for (int i = 1; i <= 16; i++) begin
      cycle(8'h02, (i >= 7 && i <= 11) ? 1'b0 : 1'b1);
      if (i >= 7 && i <= 11) check("freeze_no_changed", {7'b0, changed}, 8'h00);
      if (i == 14) check("freeze_dout_e14", dout, 8'h00);
      if (i == 15) begin
        check("freeze_dout_e15", dout, 8'h02);
        check("freeze_rise_e15", rise, 8'h02);
      end
    end

    repeat (12) cycle(8'h00, 1'b1);

    // Mid-count reset restarts the full latency
    repeat (6) cycle(8'hFF, 1'b1);
    async_reset();
    repeat (2) cycle(8'hFF, 1'b1);
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cycle(8'hFF, 1'b1);
      if (i == 9) check("midrst_dout_e9", dout, 8'h00);
      if (i == 10) check("midrst_dout_e10", dout, 8'hFF);
    end

    // Randomized segments with glitches, enable gaps and occasional resets
    for (int seg = 0; seg < 70; seg++) begin
      if ($urandom_range(0, 19) == 0) begin
        async_reset();
        cycle(W'($urandom), 1'b1);
        rst_n = 1'b1;
      end
      hold = int'($urandom_range(1, 12));
      d    = W'($urandom);
      for (int k = 0; k < hold; k++) cycle(d, ($urandom_range(0, 7) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
